// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Owns the fetch PC in front of a combinational program ROM. It converts
//   the byte PC into a ROM word index and registers each fetched instruction
//   into a one-entry valid/ready output stage that feeds decode. It accepts
//   branch/jump redirects from execute and traps illegal fetch addresses in a
//   sticky FAULT state that only reset can leave.
//
// Ports:
//   clk                in   1   clock, all state updates on posedge
//   reset              in   1   asynchronous, active-low reset
//   Redirect_Valid_i   in   1   execute requests a PC change this cycle
//   Redirect_Target_i  in   DW  byte target of the redirect
//   Out_Ready_i        in   1   decode accepts the output register this cycle
//   Rom_Instruction_i  in   DW  combinational ROM data for Rom_Address_o
//   Rom_Address_o      out  DW  ROM word index of the fetch PC
//   Instr_Valid_o      out  1   output register holds a valid instruction
//   Instr_o            out  DW  registered instruction
//   PC_o               out  DW  byte PC of Instr_o
//   PC_Plus4_o         out  DW  PC_o + 4
//   Fault_o            out  1   sticky illegal-fetch flag
//   Fault_Addr_o       out  DW  offending byte address
//   Fetch_Count_o      out  DW  accepted handshakes, wraps
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Redirect_Valid_i,
  input  logic [DATA_WIDTH-1:0] Redirect_Target_i,
  input  logic                  Out_Ready_i,
  input  logic [DATA_WIDTH-1:0] Rom_Instruction_i,
  output logic [DATA_WIDTH-1:0] Rom_Address_o,
  output logic                  Instr_Valid_o,
  output logic [DATA_WIDTH-1:0] Instr_o,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic [DATA_WIDTH-1:0] PC_Plus4_o,
  output logic                  Fault_o,
  output logic [DATA_WIDTH-1:0] Fault_Addr_o,
  output logic [DATA_WIDTH-1:0] Fetch_Count_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  // Upper bound is computed one bit wider so a text segment ending at the
  // top of the address space does not wrap to zero.
  localparam logic [DATA_WIDTH:0] LP_SPAN  = (DATA_WIDTH+1)'(MEMORY_DEPTH) << 2;
  localparam logic [DATA_WIDTH:0] LP_LIMIT = {1'b0, TEXT_BASE} + LP_SPAN;

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_fetch_pc;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_fault_addr;
  logic [DATA_WIDTH-1:0] r_count;

  logic                  w_load;
  logic                  w_pc_legal;
  logic                  w_target_legal;
  logic [DATA_WIDTH-1:0] w_rom_offset;

  function automatic logic f_legal(input logic [DATA_WIDTH-1:0] addr);
    return (addr[1:0] == 2'b00) && (addr >= TEXT_BASE) && ({1'b0, addr} < LP_LIMIT);
  endfunction

  // The output register may be (re)loaded when empty or being consumed.
  assign w_load         = !r_valid || Out_Ready_i;
  assign w_pc_legal     = f_legal(r_fetch_pc);
  assign w_target_legal = f_legal(Redirect_Target_i);
  assign w_rom_offset   = r_fetch_pc - TEXT_BASE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_fetch_pc   <= TEXT_BASE;
      r_valid      <= 1'b0;
      r_instr      <= '0;
      r_pc         <= '0;
      r_fault_addr <= '0;
      r_count      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_RUN;
        end

        S_RUN: begin
          // Decode took the current entry, even if a redirect then flushes
          // whatever would have followed it.
          if (r_valid && Out_Ready_i) begin
            r_count <= r_count + DATA_WIDTH'(1);
          end

          if (Redirect_Valid_i) begin
            r_valid <= 1'b0;
            if (w_target_legal) begin
              r_fetch_pc <= Redirect_Target_i;
            end else begin
              r_state      <= S_FAULT;
              r_fault_addr <= Redirect_Target_i;
            end
          end else if (w_load && !w_pc_legal) begin
            // Only fault when the bad PC would actually be loaded, so a
            // stalled last instruction is not dropped early.
            r_state      <= S_FAULT;
            r_fault_addr <= r_fetch_pc;
            r_valid      <= 1'b0;
          end else if (w_load) begin
            r_instr    <= Rom_Instruction_i;
            r_pc       <= r_fetch_pc;
            r_valid    <= 1'b1;
            r_fetch_pc <= r_fetch_pc + DATA_WIDTH'(4);
          end
        end

        S_FAULT: begin
          r_valid <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Rom_Address_o = {2'b00, w_rom_offset[DATA_WIDTH-1:2]};
  assign Instr_Valid_o = r_valid;
  assign Instr_o       = r_instr;
  assign PC_o          = r_pc;
  assign PC_Plus4_o    = r_pc + DATA_WIDTH'(4);
  assign Fault_o       = (r_state == S_FAULT);
  assign Fault_Addr_o  = r_fault_addr;
  assign Fetch_Count_o = r_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        reset2;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        out_ready;

  logic [31:0] rom [0:63];

  // Main DUT (64-word ROM)
  logic [31:0] rom_addr, rom_data, instr, pc, pc_plus4, fault_addr, fcount;
  logic        valid, fault;

  // Small DUT (4-word ROM) for running off the end
  logic [31:0] rom_addr2, rom_data2, instr2, pc2, pc_plus4_2, fault_addr2, fcount2;
  logic        valid2, fault2;

  int n_tests;
  int n_fail;

  assign rom_data  = (rom_addr  < 32'd64) ? rom[rom_addr[5:0]]  : 32'h0;
  assign rom_data2 = (rom_addr2 < 32'd64) ? rom[rom_addr2[5:0]] : 32'h0;

  instruction_fetch_unit dut (
    .clk               (clk),
    .reset             (reset),
    .Redirect_Valid_i  (redir_valid),
    .Redirect_Target_i (redir_target),
    .Out_Ready_i       (out_ready),
    .Rom_Instruction_i (rom_data),
    .Rom_Address_o     (rom_addr),
    .Instr_Valid_o     (valid),
    .Instr_o           (instr),
    .PC_o              (pc),
    .PC_Plus4_o        (pc_plus4),
    .Fault_o           (fault),
    .Fault_Addr_o      (fault_addr),
    .Fetch_Count_o     (fcount)
  );

  instruction_fetch_unit #(.MEMORY_DEPTH(4)) dut_small (
    .clk               (clk),
    .reset             (reset2),
    .Redirect_Valid_i  (1'b0),
    .Redirect_Target_i (32'h0),
    .Out_Ready_i       (1'b1),
    .Rom_Instruction_i (rom_data2),
    .Rom_Address_o     (rom_addr2),
    .Instr_Valid_o     (valid2),
    .Instr_o           (instr2),
    .PC_o              (pc2),
    .PC_Plus4_o        (pc_plus4_2),
    .Fault_o           (fault2),
    .Fault_Addr_o      (fault_addr2),
    .Fetch_Count_o     (fcount2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %08h", tag, got);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_entry(input string tag, input logic [31:0] e_pc,
                             input logic [31:0] e_instr, input logic [31:0] e_cnt);
    check({tag, ".valid"}, {31'd0, valid}, 32'd1);
    check({tag, ".pc"},    pc,       e_pc);
    check({tag, ".instr"}, instr,    e_instr);
    check({tag, ".pc4"},   pc_plus4, e_pc + 32'd4);
    check({tag, ".cnt"},   fcount,   e_cnt);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".valid"}, {31'd0, valid}, 32'd0);
    check({tag, ".instr"}, instr,      32'd0);
    check({tag, ".pc"},    pc,         32'd0);
    check({tag, ".fault"}, {31'd0, fault}, 32'd0);
    check({tag, ".faddr"}, fault_addr, 32'd0);
    check({tag, ".cnt"},   fcount,     32'd0);
    check({tag, ".romad"}, rom_addr,   32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 64; i++) rom[i] = (i + 1) * 32'h11;

    reset        = 1'b0;
    reset2       = 1'b0;
    redir_valid  = 1'b0;
    redir_target = 32'h0;
    out_ready    = 1'b1;
    repeat (2) step();
    check_reset_vals("rst");
    check("rst.pc4", pc_plus4, 32'd4);

    // Scenario 1: stream from reset
    reset = 1'b1;
    step();
    check("s1.e1.valid", {31'd0, valid}, 32'd0);
    step();
    check_entry("s1.w0", 32'h0040_0000, 32'h11, 32'd0);
    step();
    check_entry("s1.w1", 32'h0040_0004, 32'h22, 32'd1);

    // Scenario 2: stall on 0x22
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_entry($sformatf("s2.stall%0d", k), 32'h0040_0004, 32'h22, 32'd1);
    end
    out_ready = 1'b1;
    step();
    check_entry("s2.w2", 32'h0040_0008, 32'h33, 32'd2);
    step();
    check_entry("s2.w3", 32'h0040_000C, 32'h44, 32'd3);

    // Scenario 6a: async reset mid-stream, checked before any edge
    out_ready = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_vals("s6.mid");
    step();
    reset = 1'b1;
    out_ready = 1'b1;
    step();
    check("s6.e1.valid", {31'd0, valid}, 32'd0);
    step();
    check_entry("s6.w0", 32'h0040_0000, 32'h11, 32'd0);
    step();
    check_entry("s6.w1", 32'h0040_0004, 32'h22, 32'd1);

    // Scenario 3: redirect while 0x22 pending (not accepted)
    out_ready    = 1'b0;
    redir_valid  = 1'b1;
    redir_target = 32'h0040_0010;
    step();
    redir_valid = 1'b0;
    check("s3.bubble.valid", {31'd0, valid}, 32'd0);
    check("s3.bubble.romad", rom_addr, 32'd4);
    check("s3.bubble.cnt",   fcount,   32'd1);
    out_ready = 1'b1;
    step();
    check_entry("s3.tgt", 32'h0040_0010, 32'h55, 32'd1);
    step();
    check_entry("s3.tgt1", 32'h0040_0014, 32'h66, 32'd2);

    // Scenario 4a: misaligned redirect faults
    out_ready    = 1'b0;
    redir_valid  = 1'b1;
    redir_target = 32'h0040_0002;
    step();
    check("s4a.fault", {31'd0, fault}, 32'd1);
    check("s4a.faddr", fault_addr, 32'h0040_0002);
    check("s4a.valid", {31'd0, valid}, 32'd0);
    redir_target = 32'h0040_0000;
    out_ready    = 1'b1;
    repeat (2) step();
    redir_valid = 1'b0;
    check("s4a.stuck.fault", {31'd0, fault}, 32'd1);
    check("s4a.stuck.faddr", fault_addr, 32'h0040_0002);
    check("s4a.stuck.valid", {31'd0, valid}, 32'd0);
    check("s4a.stuck.cnt",   fcount, 32'd2);

    // Scenario 6b: async reset while in FAULT
    reset = 1'b0;
    #1;
    check_reset_vals("s6.flt");
    step();
    reset = 1'b1;
    step();
    step();
    check_entry("s6b.w0", 32'h0040_0000, 32'h11, 32'd0);

    // Scenario 4b: redirect below the text base
    out_ready    = 1'b0;
    redir_valid  = 1'b1;
    redir_target = 32'h003F_FFFC;
    step();
    redir_valid = 1'b0;
    check("s4b.fault", {31'd0, fault}, 32'd1);
    check("s4b.faddr", fault_addr, 32'h003F_FFFC);
    check("s4b.valid", {31'd0, valid}, 32'd0);
    check("s4b.cnt",   fcount, 32'd0);

    // Scenario 5: 4-word ROM runs off the end
    reset2 = 1'b1;
    step();
    check("s5.e1.valid", {31'd0, valid2}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("s5.w%0d.valid", k), {31'd0, valid2}, 32'd1);
      check($sformatf("s5.w%0d.pc", k), pc2, 32'h0040_0000 + 32'(4 * k));
      check($sformatf("s5.w%0d.instr", k), instr2, 32'(k + 1) * 32'h11);
    end
    step();
    check("s5.fault", {31'd0, fault2}, 32'd1);
    check("s5.faddr", fault_addr2, 32'h0040_0010);
    check("s5.cnt",   fcount2, 32'd4);
    check("s5.valid", {31'd0, valid2}, 32'd0);
    step();
    check("s5.hold.cnt", fcount2, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
